// File: rtl/cpu_pkg.sv
// Shared constants for the register bank: default width and reset image.
// Also holds the address range check used by the bank and the scoreboard.
package cpu_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [7:0] R0_RESET = 8'd6;
    localparam logic [7:0] R1_RESET = 8'd18;

    function automatic logic [7:0] reset_val(input int idx);
        logic [7:0] v;
        unique case (1'b1)
            (idx == 0): v = R0_RESET;
            (idx == 1): v = R1_RESET;
            default:    v = 8'd0;
        endcase
        return v;
    endfunction

    function automatic logic in_range(input int addr, input int n);
        return addr < n;
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Decode/write-back side bundle of the register bank.
// master = decode + write-back mux, slave = reg_bank.
interface reg_bank_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              claim_en;
    logic [ADDR_W-1:0] claim_addr;
    logic              rs_busy;
    logic              rt_busy;
    logic              stall;

    modport master (
        output rs_addr, rt_addr,
        output wr_en, wr_addr, wr_data,
        output claim_en, claim_addr,
        input  rs_data, rt_data,
        input  rs_busy, rt_busy, stall
    );

    modport slave (
        input  rs_addr, rt_addr,
        input  wr_en, wr_addr, wr_data,
        input  claim_en, claim_addr,
        output rs_data, rt_data,
        output rs_busy, rt_busy, stall
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-load bit per register; a claim wins over a same-cycle write-back.
// Busy lookups are registered bits only; forwarding is handled by reg_bank.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_claim_en,
    input  logic [$clog2(NUM_REGS)-1:0] i_claim_addr,
    input  logic                        i_clr_en,
    input  logic [$clog2(NUM_REGS)-1:0] i_clr_addr,
    input  logic [$clog2(NUM_REGS)-1:0] i_rs_addr,
    input  logic [$clog2(NUM_REGS)-1:0] i_rt_addr,
    output logic                        o_rs_busy,
    output logic                        o_rt_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en && in_range(int'(i_clr_addr), NUM_REGS))
            w_busy_nxt[i_clr_addr] = 1'b0;
        // Applied after the clear: a new load stays outstanding.
        if (i_claim_en && in_range(int'(i_claim_addr), NUM_REGS))
            w_busy_nxt[i_claim_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    always_comb begin
        o_rs_busy = 1'b0;
        o_rt_busy = 1'b0;
        if (in_range(int'(i_rs_addr), NUM_REGS))
            o_rs_busy = r_busy[i_rs_addr];
        if (in_range(int'(i_rt_addr), NUM_REGS))
            o_rt_busy = r_busy[i_rt_addr];
    end

endmodule

// File: rtl/reg_bank.sv
// Register bank: two async read ports, one write-back port, load scoreboard.
// Define REG_BYPASS_EN to forward same-cycle write-back data to the read ports.
module reg_bank
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 4
) (
    input  logic       clk,
    input  logic       rst,
    reg_bank_if.slave  bus
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_rs_arr;
    logic [DATA_W-1:0] w_rt_arr;
    logic              w_sb_rs_busy;
    logic              w_sb_rt_busy;

    assign w_wr_ok = bus.wr_en && in_range(int'(bus.wr_addr), NUM_REGS);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= DATA_W'(reset_val(i));
        end else if (w_wr_ok) begin
            r_regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        w_rs_arr = '0;
        w_rt_arr = '0;
        if (in_range(int'(bus.rs_addr), NUM_REGS))
            w_rs_arr = r_regs[bus.rs_addr];
        if (in_range(int'(bus.rt_addr), NUM_REGS))
            w_rt_arr = r_regs[bus.rt_addr];
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .i_claim_en   (bus.claim_en),
        .i_claim_addr (bus.claim_addr),
        .i_clr_en     (bus.wr_en),
        .i_clr_addr   (bus.wr_addr),
        .i_rs_addr    (bus.rs_addr),
        .i_rt_addr    (bus.rt_addr),
        .o_rs_busy    (w_sb_rs_busy),
        .o_rt_busy    (w_sb_rt_busy)
    );

`ifdef REG_BYPASS_EN
    logic w_rs_fwd;
    logic w_rt_fwd;
    logic w_rs_clm;
    logic w_rt_clm;

    assign w_rs_fwd = w_wr_ok && (bus.wr_addr == bus.rs_addr);
    assign w_rt_fwd = w_wr_ok && (bus.wr_addr == bus.rt_addr);
    assign w_rs_clm = bus.claim_en && (bus.claim_addr == bus.rs_addr);
    assign w_rt_clm = bus.claim_en && (bus.claim_addr == bus.rt_addr);

    assign bus.rs_data = w_rs_fwd ? bus.wr_data : w_rs_arr;
    assign bus.rt_data = w_rt_fwd ? bus.wr_data : w_rt_arr;
    assign bus.rs_busy = (w_rs_fwd && !w_rs_clm) ? 1'b0 : w_sb_rs_busy;
    assign bus.rt_busy = (w_rt_fwd && !w_rt_clm) ? 1'b0 : w_sb_rt_busy;
`else
    assign bus.rs_data = w_rs_arr;
    assign bus.rt_data = w_rt_arr;
    assign bus.rs_busy = w_sb_rs_busy;
    assign bus.rt_busy = w_sb_rt_busy;
`endif

    assign bus.stall = bus.rs_busy | bus.rt_busy;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank (5 registers so that address 7 is out of range).
// Expectations follow REG_BYPASS_EN when the bench is built with it.
module tb_reg_bank;

    localparam int DW = 8;
    localparam int NR = 5;

`ifdef REG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reg_bank_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();

    reg_bank #(
        .DATA_W   (DW),
        .NUM_REGS (NR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.claim_en   = 1'b0;
        bus.claim_addr = '0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [2:0] b);
        bus.rs_addr = a;
        bus.rt_addr = b;
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    task automatic claim(input logic [2:0] a);
        bus.claim_en   = 1'b1;
        bus.claim_addr = a;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        bus.rs_addr = '0;
        bus.rt_addr = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 1: reset image
        rd(0, 1);
        chk("rst_r0", bus.rs_data, 8'd6);
        chk("rst_r1", bus.rt_data, 8'd18);
        chk("rst_stall", bus.stall, 1'b0);
        rd(2, 3);
        chk("rst_r2", bus.rs_data, 8'd0);
        chk("rst_r3", bus.rt_data, 8'd0);
        rd(4, 4);
        chk("rst_r4", bus.rs_data, 8'd0);
        chk("rst_busy", {bus.rs_busy, bus.rt_busy}, 2'b00);

        // 2: write r2, then out-of-range write
        wr(2, 8'h5A);
        rd(2, 2);
        chk("w2_same_rs", bus.rs_data, BYP ? 8'h5A : 8'h00);
        chk("w2_same_rt", bus.rt_data, BYP ? 8'h5A : 8'h00);
        tick();
        idle();
        rd(2, 2);
        chk("w2_rs", bus.rs_data, 8'h5A);
        chk("w2_rt", bus.rt_data, 8'h5A);
        wr(7, 8'hEE);
        claim(7);
        tick();
        idle();
        rd(0, 1);
        chk("oor_r0", bus.rs_data, 8'd6);
        chk("oor_r1", bus.rt_data, 8'd18);
        rd(2, 3);
        chk("oor_r2", bus.rs_data, 8'h5A);
        chk("oor_r3", bus.rt_data, 8'h00);
        rd(4, 4);
        chk("oor_r4", bus.rs_data, 8'h00);
        chk("oor_stall", bus.stall, 1'b0);

        // 3: claim r1, then write-back r1
        claim(1);
        rd(1, 2);
        chk("clm_same_busy", bus.rs_busy, 1'b0);
        tick();
        idle();
        rd(1, 2);
        chk("clm_rs_busy", bus.rs_busy, 1'b1);
        chk("clm_rt_busy", bus.rt_busy, 1'b0);
        chk("clm_stall", bus.stall, 1'b1);
        wr(1, 8'h33);
        rd(1, 2);
        chk("wb_same_busy", bus.rs_busy, BYP ? 1'b0 : 1'b1);
        chk("wb_same_data", bus.rs_data, BYP ? 8'h33 : 8'd18);
        chk("wb_same_stall", bus.stall, BYP ? 1'b0 : 1'b1);
        tick();
        idle();
        rd(1, 2);
        chk("wb_busy", bus.rs_busy, 1'b0);
        chk("wb_data", bus.rs_data, 8'h33);
        chk("wb_stall", bus.stall, 1'b0);

        // double claim on r4 keeps a single bit; one write-back clears it
        claim(4);
        tick();
        claim(4);
        tick();
        idle();
        rd(0, 4);
        chk("dbl_busy", bus.rt_busy, 1'b1);
        wr(4, 8'h77);
        tick();
        idle();
        rd(0, 4);
        chk("dbl_clr", bus.rt_busy, 1'b0);
        chk("dbl_data", bus.rt_data, 8'h77);

        // 4: same-cycle claim and write-back to r3
        claim(3);
        wr(3, 8'h11);
        rd(0, 3);
        chk("cw_same_busy", bus.rt_busy, 1'b0);
        chk("cw_same_data", bus.rt_data, BYP ? 8'h11 : 8'h00);
        tick();
        idle();
        rd(0, 3);
        chk("cw_data", bus.rt_data, 8'h11);
        chk("cw_busy", bus.rt_busy, 1'b1);
        chk("cw_stall", bus.stall, 1'b1);
        claim(3);
        wr(3, 8'h22);
        rd(0, 3);
        chk("cw2_same_busy", bus.rt_busy, 1'b1);
        tick();
        idle();
        wr(3, 8'h23);
        tick();
        idle();
        rd(0, 3);
        chk("cw2_clr", bus.rt_busy, 1'b0);
        chk("cw2_data", bus.rt_data, 8'h23);

        // 5: write r0, both ports on r0
        wr(0, 8'hFF);
        rd(0, 0);
        chk("byp_rs", bus.rs_data, BYP ? 8'hFF : 8'd6);
        chk("byp_rt", bus.rt_data, BYP ? 8'hFF : 8'd6);
        tick();
        idle();
        rd(0, 0);
        chk("r0_rs", bus.rs_data, 8'hFF);
        chk("r0_rt", bus.rt_data, 8'hFF);

        // 6: claim r2, reset before write-back (reset beats wr/claim)
        claim(2);
        tick();
        idle();
        rd(2, 3);
        chk("ld_busy", bus.rs_busy, 1'b1);
        rst = 1'b1;
        wr(3, 8'h99);
        claim(3);
        tick();
        rst = 1'b0;
        idle();
        rd(2, 3);
        chk("rl_busy", {bus.rs_busy, bus.rt_busy}, 2'b00);
        chk("rl_r2", bus.rs_data, 8'h00);
        chk("rl_r3", bus.rt_data, 8'h00);
        rd(0, 1);
        chk("rl_r0", bus.rs_data, 8'd6);
        chk("rl_r1", bus.rt_data, 8'd18);
        wr(2, 8'h44);
        tick();
        idle();
        rd(2, 2);
        chk("late_data", bus.rs_data, 8'h44);
        chk("late_busy", bus.rs_busy, 1'b0);
        chk("late_stall", bus.stall, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
